// File: rtl/mc_seq_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: states, fault codes, next-PC selects
// and the RV32I-subset opcodes also used by the combinational control decoder.
package mc_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    FaultNone    = 2'b00,
    FaultTimeout = 2'b01,
    FaultIllegal = 2'b10
  } fault_e;

  localparam logic [1:0] NpcPc4 = 2'b00;
  localparam logic [1:0] NpcBeq = 2'b01;
  localparam logic [1:0] NpcJmp = 2'b10;
  localparam logic [1:0] NpcAlu = 2'b11;

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpJalr = 7'b1100111;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpB    = 7'b1100011;
  localparam logic [6:0] OpLui  = 7'b0110111;
  localparam logic [6:0] OpJal  = 7'b1101111;

  function automatic logic opcode_legal(input logic [6:0] op);
    return (op == OpR)  || (op == OpI)  || (op == OpLw)  || (op == OpJalr) ||
           (op == OpSw) || (op == OpB)  || (op == OpLui) || (op == OpJal);
  endfunction

endpackage

// File: rtl/mc_seq_ctrl_mem_wait_timer.sv
// Counts request cycles without an ack; flags a timeout on request cycle WAIT_MAX
// unless the ack arrives in that same cycle.
module mc_seq_ctrl_mem_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic req,
  input  logic ack,
  output logic timeout
);

  localparam int unsigned CntW = $clog2(WAIT_MAX + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (req && !ack) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // cnt_q holds the number of prior unacked cycles, so request cycle n sees n-1.
  assign timeout = req && !ack && (cnt_q == CntW'(WAIT_MAX - 1));

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB over a
// shared acked memory and gates every architectural write strobe.
module mc_seq_ctrl
  import mc_seq_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        br_flag,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_is_data,
  output logic        mem_we,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        pc_we,
  output logic [1:0]  npc_op,
  output logic        rf_we,
  output logic        instret,
  output logic [1:0]  fault,
  output logic [2:0]  state
);

  state_e     state_q, state_d;
  fault_e     fault_q, fault_d;
  logic [6:0] opcode_q, opcode_d;
  logic       timer_clr, timer_req, timeout;
  logic       unused_inst;

  assign unused_inst = ^inst[31:7];

  assign timer_req = rst_n && ((state_q == StFetch) || (state_q == StMem));

  mc_seq_ctrl_mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .req     (timer_req),
    .ack     (mem_ack),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      fault_q  <= FaultNone;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      fault_q  <= fault_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    opcode_d    = opcode_q;
    mem_req     = 1'b0;
    mem_is_data = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    mdr_we      = 1'b0;
    pc_we       = 1'b0;
    npc_op      = NpcPc4;
    rf_we       = 1'b0;
    instret     = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end else if (timeout) begin
          fault_d = FaultTimeout;
          state_d = StHalt;
        end
      end
      StDecode: begin
        opcode_d = inst[6:0];
        if (opcode_legal(inst[6:0])) begin
          state_d = StExec;
        end else begin
          fault_d = FaultIllegal;
          state_d = StHalt;
        end
      end
      StExec: begin
        if ((opcode_q == OpLw) || (opcode_q == OpSw)) begin
          state_d = StMem;
        end else if (opcode_q == OpB) begin
          pc_we   = 1'b1;
          npc_op  = br_flag ? NpcBeq : NpcPc4;
          instret = 1'b1;
          state_d = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        mem_req     = 1'b1;
        mem_is_data = 1'b1;
        mem_we      = (opcode_q == OpSw);
        if (mem_ack) begin
          if (opcode_q == OpSw) begin
            pc_we   = 1'b1;
            instret = 1'b1;
            state_d = StFetch;
          end else begin
            mdr_we  = 1'b1;
            state_d = StWb;
          end
        end else if (timeout) begin
          fault_d = FaultTimeout;
          state_d = StHalt;
        end
      end
      StWb: begin
        // PC and RF update at the same edge so JAL/JALR link the old PC+4.
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        instret = 1'b1;
        if (opcode_q == OpJal) begin
          npc_op = NpcJmp;
        end else if (opcode_q == OpJalr) begin
          npc_op = NpcAlu;
        end
        state_d = StFetch;
      end
      StHalt: begin
      end
      default: state_d = StHalt;
    endcase

    timer_clr = (state_d != state_q) && ((state_d == StFetch) || (state_d == StMem));

    // Reset aborts whatever is in flight without a final write.
    if (!rst_n) begin
      mem_req     = 1'b0;
      mem_is_data = 1'b0;
      mem_we      = 1'b0;
      ir_we       = 1'b0;
      mdr_we      = 1'b0;
      pc_we       = 1'b0;
      npc_op      = NpcPc4;
      rf_we       = 1'b0;
      instret     = 1'b0;
    end
  end

  assign fault = rst_n ? fault_q : FaultNone;
  assign state = rst_n ? state_q : StFetch;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Directed bench for mc_seq_ctrl: walks each instruction class cycle by cycle and checks
// strobes, state and fault against hand-derived expectations.
module tb_mc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        br_flag;
  logic        mem_ack;
  logic        mem_req, mem_is_data, mem_we, ir_we, mdr_we, pc_we, rf_we, instret;
  logic [1:0]  npc_op, fault;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_seq_ctrl #(
    .WAIT_MAX (15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst        (inst),
    .br_flag     (br_flag),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_is_data (mem_is_data),
    .mem_we      (mem_we),
    .ir_we       (ir_we),
    .mdr_we      (mdr_we),
    .pc_we       (pc_we),
    .npc_op      (npc_op),
    .rf_we       (rf_we),
    .instret     (instret),
    .fault       (fault),
    .state       (state)
  );

  // {req, is_data, we, ir_we, mdr_we, pc_we, npc_op[1:0], rf_we, instret}
  logic [9:0] strb;
  assign strb = {mem_req, mem_is_data, mem_we, ir_we, mdr_we, pc_we, npc_op, rf_we, instret};

  localparam logic [9:0] Idle     = 10'b0000000000;
  localparam logic [9:0] FetchNo  = 10'b1000000000;
  localparam logic [9:0] FetchAck = 10'b1001000000;
  localparam logic [9:0] WbPc4    = 10'b0000010011;
  localparam logic [9:0] WbJmp    = 10'b0000011011;
  localparam logic [9:0] WbAlu    = 10'b0000011111;
  localparam logic [9:0] BrTaken  = 10'b0000010101;
  localparam logic [9:0] BrNot    = 10'b0000010001;
  localparam logic [9:0] LwNo     = 10'b1100000000;
  localparam logic [9:0] LwAck    = 10'b1100100000;
  localparam logic [9:0] SwNo     = 10'b1110000000;
  localparam logic [9:0] SwAck    = 10'b1110010001;

  localparam logic [31:0] IAddi = 32'h0010_0093;
  localparam logic [31:0] IBeq  = 32'h0000_0063;
  localparam logic [31:0] ILw   = 32'h0000_2083;
  localparam logic [31:0] ISw   = 32'h0010_2023;
  localparam logic [31:0] IJal  = 32'h0000_006f;
  localparam logic [31:0] IJalr = 32'h0000_0067;
  localparam logic [31:0] ILui  = 32'h0000_10b7;
  localparam logic [31:0] IBad  = 32'h0000_007f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered #1 after a rising edge; drives inputs, checks, then moves to the next cycle.
  task automatic cyc(input logic ack, input logic br, input logic [9:0] es,
                     input logic [2:0] est, input string tag);
    mem_ack = ack;
    br_flag = br;
    #2;
    chk({tag, ".strb"}, 32'(strb), 32'(es));
    chk({tag, ".state"}, 32'(state), 32'(est));
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse(input string tag);
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    #2;
    chk({tag, ".strb_in_rst"}, 32'(strb), 32'(Idle));
    chk({tag, ".state_in_rst"}, 32'(state), 32'd0);
    chk({tag, ".fault_in_rst"}, 32'(fault), 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    mem_ack = 1'b0;
    #1;
    chk({tag, ".fault_after"}, 32'(fault), 32'd0);
    chk({tag, ".state_after"}, 32'(state), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    inst    = IAddi;
    br_flag = 1'b0;
    mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    #1;
    chk("reset.strb", 32'(strb), 32'(Idle));
    chk("reset.state", 32'(state), 32'd0);
    chk("reset.fault", 32'(fault), 32'd0);
    mem_ack = 1'b0;
    rst_n   = 1'b1;

    // ADDI, zero-wait: 4 cycles, retire in WB
    cyc(1'b1, 1'b0, FetchAck, 3'd0, "addi.c1");
    cyc(1'b0, 1'b0, Idle,     3'd1, "addi.c2");
    cyc(1'b0, 1'b0, Idle,     3'd2, "addi.c3");
    cyc(1'b0, 1'b0, WbPc4,    3'd4, "addi.c4");

    // BEQ taken; stray ack in DECODE must be ignored
    inst = IBeq;
    cyc(1'b1, 1'b0, FetchAck, 3'd0, "beqt.c1");
    cyc(1'b1, 1'b1, Idle,     3'd1, "beqt.c2");
    cyc(1'b0, 1'b1, BrTaken,  3'd2, "beqt.c3");
    cyc(1'b1, 1'b0, FetchAck, 3'd0, "beqn.c1");
    cyc(1'b0, 1'b0, Idle,     3'd1, "beqn.c2");
    cyc(1'b0, 1'b0, BrNot,    3'd2, "beqn.c3");

    // LW with 3 wait cycles on the data access: 8 cycles
    inst = ILw;
    cyc(1'b1, 1'b0, FetchAck, 3'd0, "lw.c1");
    cyc(1'b0, 1'b0, Idle,     3'd1, "lw.c2");
    cyc(1'b0, 1'b0, Idle,     3'd2, "lw.c3");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, LwNo, 3'd3, "lw.wait");
    cyc(1'b1, 1'b0, LwAck,    3'd3, "lw.c7");
    cyc(1'b0, 1'b0, WbPc4,    3'd4, "lw.c8");

    // SW retires on the MEM ack, skipping WB
    inst = ISw;
    cyc(1'b1, 1'b0, FetchAck, 3'd0, "sw.c1");
    cyc(1'b0, 1'b0, Idle,     3'd1, "sw.c2");
    cyc(1'b0, 1'b0, Idle,     3'd2, "sw.c3");
    cyc(1'b1, 1'b0, SwAck,    3'd3, "sw.c4");

    inst = IJal;
    cyc(1'b1, 1'b0, FetchAck, 3'd0, "jal.c1");
    cyc(1'b0, 1'b0, Idle,     3'd1, "jal.c2");
    cyc(1'b0, 1'b0, Idle,     3'd2, "jal.c3");
    cyc(1'b0, 1'b0, WbJmp,    3'd4, "jal.c4");
    inst = IJalr;
    cyc(1'b1, 1'b0, FetchAck, 3'd0, "jalr.c1");
    cyc(1'b0, 1'b0, Idle,     3'd1, "jalr.c2");
    cyc(1'b0, 1'b0, Idle,     3'd2, "jalr.c3");
    cyc(1'b0, 1'b0, WbAlu,    3'd4, "jalr.c4");
    inst = ILui;
    cyc(1'b1, 1'b0, FetchAck, 3'd0, "lui.c1");
    cyc(1'b0, 1'b0, Idle,     3'd1, "lui.c2");
    cyc(1'b0, 1'b0, Idle,     3'd2, "lui.c3");
    cyc(1'b0, 1'b0, WbPc4,    3'd4, "lui.c4");

    // Fetch ack on request cycle 15 beats the timeout
    inst = IAddi;
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, FetchNo, 3'd0, "late.wait");
    cyc(1'b1, 1'b0, FetchAck, 3'd0, "late.c15");
    chk("late.fault", 32'(fault), 32'd0);
    cyc(1'b0, 1'b0, Idle,     3'd1, "late.dec");
    cyc(1'b0, 1'b0, Idle,     3'd2, "late.exe");
    cyc(1'b0, 1'b0, WbPc4,    3'd4, "late.wb");

    // No ack for 15 fetch cycles: timeout fault, HALT ignores acks
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, FetchNo, 3'd0, "fto.wait");
    cyc(1'b1, 1'b1, Idle, 3'd5, "fto.halt");
    chk("fto.fault", 32'(fault), 32'd1);
    rst_pulse("fto.rst");

    // Illegal opcode halts after DECODE
    inst = IBad;
    cyc(1'b1, 1'b0, FetchAck, 3'd0, "ill.c1");
    cyc(1'b0, 1'b0, Idle,     3'd1, "ill.c2");
    cyc(1'b0, 1'b0, Idle,     3'd5, "ill.halt");
    chk("ill.fault", 32'(fault), 32'd2);
    rst_pulse("ill.rst");

    // Data-side timeout during LW
    inst = ILw;
    cyc(1'b1, 1'b0, FetchAck, 3'd0, "mto.c1");
    cyc(1'b0, 1'b0, Idle,     3'd1, "mto.c2");
    cyc(1'b0, 1'b0, Idle,     3'd2, "mto.c3");
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, LwNo, 3'd3, "mto.wait");
    cyc(1'b0, 1'b0, Idle, 3'd5, "mto.halt");
    chk("mto.fault", 32'(fault), 32'd1);
    rst_pulse("mto.rst");

    // Reset in the middle of an SW data access: no write strobe
    inst = ISw;
    cyc(1'b1, 1'b0, FetchAck, 3'd0, "swr.c1");
    cyc(1'b0, 1'b0, Idle,     3'd1, "swr.c2");
    cyc(1'b0, 1'b0, Idle,     3'd2, "swr.c3");
    mem_ack = 1'b0;
    #2;
    chk("swr.mem_strb", 32'(strb), 32'(SwNo));
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    #1;
    chk("swr.no_we", 32'(mem_we), 32'd0);
    chk("swr.strb_rst", 32'(strb), 32'(Idle));
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    mem_ack = 1'b0;
    cyc(1'b0, 1'b0, FetchNo, 3'd0, "swr.refetch");
    chk("swr.fault", 32'(fault), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
